// File: rtl/sfr_shift_apply.sv
// Sequential mantissa shifter applying a signed shift factor (+n right, -n left), one bit per cycle.
// Define SHIFT4_EN to take 4-bit steps while at least 4 positions remain.
module sfr_shift_apply #(
  parameter int unsigned W  = 25,
  parameter int unsigned SW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  mant_in,
  input  logic [SW-1:0] sfr_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  mant_out,
  output logic          sticky_out,
  output logic          ovf_out
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   mant_q, mant_d;
  logic [W-1:0]   res_q, res_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic           sticky_q, sticky_d;
  logic           ovf_q, ovf_d;
  logic [SW-1:0]  mag;
  logic [CW-1:0]  cnt_init;

  // Magnitude is taken as unsigned so that the most negative factor maps to 2^(SW-1).
  always_comb begin
    mag      = sfr_in[SW-1] ? (~sfr_in + SW'(1)) : sfr_in;
    cnt_init = (32'(mag) > W) ? CW'(W) : CW'(mag);
  end

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d   = mant_in;
          dir_d    = sfr_in[SW-1];
          cnt_d    = cnt_init;
          sticky_d = 1'b0;
          ovf_d    = 1'b0;
          if (cnt_init == '0) begin
            state_d = DONE;
            res_d   = mant_in;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (dir_q) begin
          mant_d = {mant_q[W-2:0], 1'b0};
          ovf_d  = ovf_q | mant_q[W-1];
        end else begin
          mant_d   = {1'b0, mant_q[W-1:1]};
          sticky_d = sticky_q | mant_q[0];
        end
        cnt_d = cnt_q - CW'(1);
`ifdef SHIFT4_EN
        if (cnt_q >= CW'(4)) begin
          if (dir_q) begin
            mant_d = {mant_q[W-5:0], 4'b0000};
            ovf_d  = ovf_q | (|mant_q[W-1:W-4]);
          end else begin
            mant_d   = {4'b0000, mant_q[W-1:4]};
            sticky_d = sticky_q | (|mant_q[3:0]);
          end
          cnt_d = cnt_q - CW'(4);
        end
`endif
        if (cnt_d == '0) begin
          state_d = DONE;
          res_d   = mant_d;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mant_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign mant_out   = res_q;
  assign sticky_out = sticky_q;
  assign ovf_out    = ovf_q;

endmodule

// File: tb/tb_sfr_shift_apply.sv
// Directed-vector bench for sfr_shift_apply; latency expectations follow SHIFT4_EN when defined.
module tb_sfr_shift_apply;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] mant_in;
  logic [7:0]  sfr_in;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] mant_out;
  logic        sticky_out;
  logic        ovf_out;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  sfr_shift_apply #(.W(25), .SW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mant_in    (mant_in),
    .sfr_in     (sfr_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mant_out   (mant_out),
    .sticky_out (sticky_out),
    .ovf_out    (ovf_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int unsigned shift_cycles(input int unsigned n);
`ifdef SHIFT4_EN
    return n / 4 + n % 4;
`else
    return n;
`endif
  endfunction

  // Accept at edge t; latency k means out_valid is first seen at edge t+k.
  task automatic run_job(input string tag, input logic [24:0] m, input logic [7:0] s,
                         input int unsigned n, input logic [24:0] em, input logic es, input logic eo);
    int unsigned lat;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; mant_in = m; sfr_in = s;
    @(posedge clk); #1;
    in_valid = 1'b0; mant_in = '0; sfr_in = '0;
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    chk({tag, "_lat"}, lat, shift_cycles(n) + 1);
    chk({tag, "_mant"}, 32'(mant_out), 32'(em));
    chk({tag, "_sticky"}, 32'(sticky_out), 32'(es));
    chk({tag, "_ovf"}, 32'(ovf_out), 32'(eo));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_vld_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned stale;
    int unsigned w;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mant_in = '0; sfr_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mant", 32'(mant_out), 32'd0);
    chk("rst_sticky", 32'(sticky_out), 32'd0);
    chk("rst_ovf", 32'(ovf_out), 32'd0);
    rst_n = 1'b1;

    run_job("t1_l24",   25'h0000001, 8'hE8, 24, 25'h1000000, 1'b0, 1'b0);
    run_job("t2_r1",    25'h1800003, 8'h01, 1,  25'h0C00001, 1'b1, 1'b0);
    run_job("t3_l2",    25'h1000001, 8'hFE, 2,  25'h0000004, 1'b0, 1'b1);
    run_job("t3_zero",  25'h1000001, 8'h00, 0,  25'h1000001, 1'b0, 1'b0);
    run_job("t4_m128",  25'h1555555, 8'h80, 25, 25'h0000000, 1'b0, 1'b1);
    run_job("t4_p127",  25'h1555555, 8'h7F, 25, 25'h0000000, 1'b1, 1'b0);
    run_job("r4_lost",  25'h000000F, 8'h04, 4,  25'h0000000, 1'b1, 1'b0);
    run_job("r6_clean", 25'h1000040, 8'h06, 6,  25'h0040001, 1'b0, 1'b0);
    run_job("l5",       25'h0000003, 8'hFB, 5,  25'h0000060, 1'b0, 1'b0);
    run_job("l1_ovf",   25'h1FFFFFF, 8'hFF, 1,  25'h1FFFFFE, 1'b0, 1'b1);
    run_job("r25_zero", 25'h0000000, 8'h19, 25, 25'h0000000, 1'b0, 1'b0);

    // Stall in DONE while new input is offered
    @(negedge clk);
    in_valid = 1'b1; mant_in = 25'h1800003; sfr_in = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (w < 50 && !out_valid) begin @(negedge clk); w++; end
    chk("stall_reach_done", 32'(out_valid), 32'd1);
    in_valid = 1'b1; mant_in = 25'h1FFFFFF; sfr_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_vld", 32'(out_valid), 32'd1);
      chk("stall_mant", 32'(mant_out), 32'h0C00001);
      chk("stall_rdy", 32'(in_ready), 32'd0);
    end
    chk("stall_sticky", 32'(sticky_out), 32'd1);
    chk("stall_ovf", 32'(ovf_out), 32'd0);
    in_valid = 1'b0; mant_in = '0; sfr_in = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_hold_mant", 32'(mant_out), 32'h0C00001);
    chk("idle_vld", 32'(out_valid), 32'd0);
    chk("idle_rdy", 32'(in_ready), 32'd1);

    // Reset in the middle of a 16-bit left shift
    @(negedge clk);
    in_valid = 1'b1; mant_in = 25'h0000001; sfr_in = 8'hF0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_mant", 32'(mant_out), 32'd0);
    chk("mid_rst_sticky", 32'(sticky_out), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 32'(in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("post_rst_no_stale", stale, 32'd0);

    run_job("recover", 25'h0000001, 8'hF0, 16, 25'h0010000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
